// File: rtl/riscv_inst_encoder.sv
// RV32I instruction encoder: packs opcode/register/funct/immediate fields into words,
// expands LI into ADDI, LUI or LUI+ADDI, and emits through one valid/ready output register.
module riscv_inst_encoder #(
  parameter bit          CHECK_RANGE = 1'b1,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ONE = 2'd1, FIRST = 2'd2} state_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t      state_r;
  logic        out_valid_r;
  logic        out_last_r;
  logic        out_err_r;
  logic [31:0] out_inst_r;
  logic [31:0] pend_r;

  logic [31:0] enc_word_s;
  logic [31:0] enc_second_s;
  logic [31:0] load_word_s;
  logic [19:0] li_hi_s;
  logic        enc_err_s;
  logic        enc_two_s;
  logic        accept_s;

  // True when v is representable as a two's-complement number of the given width.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic [31:0] top;
    top = 32'($signed(v) >>> (bits - 1));
    return (top == 32'h0000_0000) || (top == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // off carries imm[12:1]; bit 0 of a branch offset is never encoded.
  function automatic logic [31:0] enc_b(input logic [11:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {off[11], off[9:4], rs2, rs1, f3, off[3:0], off[10], op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] hi, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {hi, rd, op};
  endfunction

  // off carries imm[20:1].
  function automatic logic [31:0] enc_j(input logic [19:0] off, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {off[19], off[9:0], off[10], off[18:11], rd, op};
  endfunction

  // Upper part of (imm + 0x800): ADDI sign-extends lo, so LUI must pre-compensate.
  assign li_hi_s = in_imm[31:12] + {19'd0, in_imm[11]};

  // Encode the request currently on the input port.
  always_comb begin
    enc_word_s   = NOP_INST;
    enc_second_s = NOP_INST;
    enc_err_s    = 1'b0;
    enc_two_s    = 1'b0;
    case (in_fmt)
      3'd0: enc_word_s = enc_r(in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode);
      3'd1: begin
        enc_word_s = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode);
        enc_err_s  = CHECK_RANGE && !fits_signed(in_imm, 12);
      end
      3'd2: begin
        enc_word_s = enc_s(in_imm[11:0], in_rs2, in_rs1, in_funct3, in_opcode);
        enc_err_s  = CHECK_RANGE && !fits_signed(in_imm, 12);
      end
      3'd3: begin
        enc_word_s = enc_b(in_imm[12:1], in_rs2, in_rs1, in_funct3, in_opcode);
        enc_err_s  = CHECK_RANGE && (in_imm[0] || !fits_signed(in_imm, 13));
      end
      3'd4: begin
        enc_word_s = enc_u(in_imm[31:12], in_rd, in_opcode);
        enc_err_s  = CHECK_RANGE && (in_imm[11:0] != 12'h000);
      end
      3'd5: begin
        enc_word_s = enc_j(in_imm[20:1], in_rd, in_opcode);
        enc_err_s  = CHECK_RANGE && (in_imm[0] || !fits_signed(in_imm, 21));
      end
      3'd6: begin
        if (fits_signed(in_imm, 12)) begin
          enc_word_s = enc_i(in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM);
        end else if (in_imm[11:0] == 12'h000) begin
          enc_word_s = enc_u(li_hi_s, in_rd, OP_LUI);
        end else begin
          enc_word_s   = enc_u(li_hi_s, in_rd, OP_LUI);
          enc_second_s = enc_i(in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM);
          enc_two_s    = 1'b1;
        end
      end
      default: enc_err_s = 1'b1;
    endcase
  end

  assign load_word_s = enc_err_s ? NOP_INST : enc_word_s;
  assign in_ready    = rst_n && ((state_r == IDLE) || ((state_r == ONE) && out_ready));
  assign accept_s    = in_valid && in_ready;

  // Output register and beat sequencing; a pending second LI word lives in pend_r.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_inst_r  <= 32'h0000_0000;
      out_last_r  <= 1'b0;
      out_err_r   <= 1'b0;
      pend_r      <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE, ONE: begin
          if (accept_s) begin
            out_valid_r <= 1'b1;
            out_inst_r  <= load_word_s;
            out_err_r   <= enc_err_s;
            out_last_r  <= !(enc_two_s && !enc_err_s);
            pend_r      <= enc_second_s;
            state_r     <= (enc_two_s && !enc_err_s) ? FIRST : ONE;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        FIRST: begin
          if (out_ready) begin
            out_inst_r <= pend_r;
            out_last_r <= 1'b1;
            out_err_r  <= 1'b0;
            state_r    <= ONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_inst  = out_inst_r;
  assign out_last  = out_last_r;
  assign out_err   = out_err_r;

endmodule
